// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths: line-state encoding,
// default baud divisor, idle line level and message-to-byte sizing.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Whole bytes needed to carry a message of the given bit width.
    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Serialises one 8N1 byte per byte_valid; byte_done marks the last cycle of the stop bit,
// where a new byte_valid chains straight into the next start bit with no idle gap.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_done,
    output logic       serial
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_t       state;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              bit_end;

    assign bit_end   = (baud == BAUD_LAST);
    assign byte_done = (state == STOP) && bit_end;

    // NOTE: every register here is updated with <= so all of them see the pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            serial  <= UART_IDLE_LEVEL;
        end else begin
            case (state)
                IDLE: begin
                    if (byte_valid) begin
                        shift  <= byte_data;
                        baud   <= '0;
                        serial <= ~UART_IDLE_LEVEL;
                        state  <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        serial  <= shift[0];
                        shift   <= shift >> 1;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            serial <= UART_IDLE_LEVEL;
                            state  <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            serial  <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        if (byte_valid) begin
                            shift  <= byte_data;
                            serial <= ~UART_IDLE_LEVEL;
                            state  <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_message_tx.sv
// Accepts a MSG_BITS message on isNew && ready and sends it most-significant byte first
// as back-to-back 8N1 frames; ready returns on the edge that ends the last stop bit.
module uart_message_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int MSG_BITS     = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [MSG_BITS-1:0] message,
    input  logic                isNew,
    output logic                ready,
    output logic                serialOut
);

    localparam int NUM_BYTES = bytes_for(MSG_BITS);
    localparam int BUF_W     = NUM_BYTES * 8;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    logic [BUF_W-1:0] word;
    logic [BUF_W-1:0] buffer;
    logic [IDX_W-1:0] byte_idx;
    logic             accept;
    logic             last_byte;
    logic             byte_done;
    logic             byte_valid;
    logic [7:0]       byte_data;

    assign word      = BUF_W'(message);
    assign accept    = isNew && ready;
    assign last_byte = (byte_idx == LAST_IDX);

    // The first byte goes straight from the input so the start bit begins on the accept edge;
    // later bytes come from the top of the buffer, handed over on the final stop-bit cycle.
    assign byte_valid = accept || (!ready && byte_done && !last_byte);
    assign byte_data  = ready ? word[BUF_W-1 -: 8] : buffer[BUF_W-1 -: 8];

    // NOTE: buffer is ordinary flops, not a RAM, so reset clears it along with the counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready    <= 1'b1;
            buffer   <= '0;
            byte_idx <= '0;
        end else if (accept) begin
            ready    <= 1'b0;
            buffer   <= word << 8;
            byte_idx <= '0;
        end else if (!ready && byte_done) begin
            if (last_byte) begin
                ready    <= 1'b1;
                buffer   <= '0;
                byte_idx <= '0;
            end else begin
                buffer   <= buffer << 8;
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clock     (clock),
        .reset     (reset),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_done (byte_done),
        .serial    (serialOut)
    );

endmodule

// File: tb/tb_uart_message_tx.sv
// Directed bench for uart_message_tx at 4 clocks per bit, 20-bit messages (3 bytes, 120 cycles).
// The line is sampled on every falling edge and decoded into bytes and frame-shape errors.
module tb_uart_message_tx;

    localparam int CPB   = 4;
    localparam int MB    = 20;
    localparam int NB    = 3;
    localparam int FRAME = NB * 10 * CPB;

    logic          clock = 1'b0;
    logic          reset;
    logic [MB-1:0] message;
    logic          isNew;
    logic          ready;
    logic          serialOut;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    uart_message_tx #(
        .CLKS_PER_BIT(CPB),
        .MSG_BITS    (MB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .message  (message),
        .isNew    (isNew),
        .ready    (ready),
        .serialOut(serialOut)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge: presents msg for the next rising edge (the accept edge k),
    // records line/ready after edges k..k+FRAME, then decodes and checks the three frames.
    task automatic send_frame(input string tag, input logic [MB-1:0] msg, input logic [MB-1:0] alt,
                              input logic hold, input int pulse_at, input logic [23:0] exp_bytes,
                              output logic [9:0] first_frame);
        logic        line[0:FRAME];
        logic        rdy[0:FRAME];
        logic [23:0] got;
        int          shape;
        int          busy;
        int          base;
        logic        level;
        check({tag, "_ready_before"}, {31'd0, ready}, 32'd1);
        message = msg;
        isNew   = 1'b1;
        for (int i = 0; i <= FRAME; i++) begin
            @(negedge clock);
            line[i] = serialOut;
            rdy[i]  = ready;
            if (i == 0) begin
                message = alt;
                isNew   = hold;
            end
            if (i == pulse_at) begin
                isNew   = 1'b1;
                message = '1;
            end else if (i == pulse_at + 1) begin
                isNew = hold;
            end
        end
        got = '0;
        shape = 0;
        busy = 0;
        first_frame = '0;
        for (int b = 0; b < NB; b++) begin
            for (int p = 0; p < 10; p++) begin
                base = (b * 10 + p) * CPB;
                for (int c = 1; c < CPB; c++)
                    if (line[base + c] !== line[base]) shape++;
                level = line[base + 1];
                if (p == 0 && level !== 1'b0) shape++;
                if (p == 9 && level !== 1'b1) shape++;
                if (p >= 1 && p <= 8) got[(NB - 1 - b) * 8 + p - 1] = level;
                if (b == 0) first_frame[p] = level;
            end
        end
        for (int i = 0; i < FRAME; i++)
            if (rdy[i] === 1'b0) busy++;
        check({tag, "_bytes"}, {8'd0, got}, {8'd0, exp_bytes});
        check({tag, "_frame_shape_errors"}, shape, 0);
        check({tag, "_busy_cycles"}, busy, FRAME);
        check({tag, "_end_idle"}, {30'd0, rdy[FRAME], line[FRAME]}, 32'd3);
    endtask

    initial begin
        logic [9:0] ff;
        int         errs;

        // 1: reset and idle
        reset   = 1'b1;
        isNew   = 1'b0;
        message = '0;
        @(negedge clock);
        @(negedge clock);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_line", {31'd0, serialOut}, 32'd1);
        reset = 1'b0;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (serialOut !== 1'b1 || ready !== 1'b1) errs++;
        end
        check("idle50_errors", errs, 0);

        // 2: single message, first frame bit pattern
        send_frame("abcde", 20'hABCDE, 20'hABCDE, 1'b0, -1, 24'h0ABCDE, ff);
        check("abcde_first_frame_bits", {22'd0, ff}, {22'd0, 10'b1000010100});

        // 3: isNew held high across two frames, one idle cycle between them
        send_frame("held1", 20'h48651, 20'h48651, 1'b1, -1, 24'h048651, ff);
        send_frame("held2", 20'h48651, 20'h48651, 1'b1, -1, 24'h048651, ff);
        isNew = 1'b0;
        check("held2_first_frame_bits", {22'd0, ff}, {22'd0, 10'b1000001000});

        // 4: request pulsed during the second byte is ignored
        send_frame("pulse", 20'hABCDE, 20'hABCDE, 1'b0, 50, 24'h0ABCDE, ff);
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (serialOut !== 1'b1 || ready !== 1'b1) errs++;
        end
        check("pulse_nothing_after", errs, 0);

        // 5: asynchronous reset during a data bit of the third byte
        message = 20'hABCDE;
        isNew   = 1'b1;
        for (int i = 0; i <= 105; i++) begin
            @(negedge clock);
            if (i == 0) isNew = 1'b0;
        end
        check("midreset_line_before", {31'd0, serialOut}, 32'd0);
        check("midreset_ready_before", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("midreset_line_now", {31'd0, serialOut}, 32'd1);
        check("midreset_ready_now", {31'd0, ready}, 32'd1);
        @(negedge clock);
        check("midreset_line_held", {31'd0, serialOut}, 32'd1);
        reset = 1'b0;
        @(negedge clock);
        send_frame("after_reset", 20'h00001, 20'h00001, 1'b0, -1, 24'h000001, ff);

        // 6: message changes the cycle after accept
        send_frame("late_change", 20'h12345, 20'h6789A, 1'b0, -1, 24'h012345, ff);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
